// File: rtl/if_pkg.sv
// Shared types for the instruction fetch stage: fetch-queue entry layout and fetch granularity.
package if_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with registered storage, wrapping pointers and a synchronous clear.
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  T              wdata,
    input  logic          pop,
    output T              rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    T                mem_q [DEPTH];
    T                mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_pop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign count  = count_q;
    assign rdata  = mem_q[rd_ptr_q];
    assign do_pop = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/if_prefetch_buffer.sv
// Instruction fetch stage: keeps iram reads in flight under a credit limit and queues the
// returned {pc, instr} pairs toward ID; branch redirects restart fetch and discard stale returns.
module if_prefetch_buffer
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET_ADDR   = '0,
    parameter int              FQ_DEPTH        = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            id_pipe_valid,
    input  logic            id_pipe_ready,
    input  logic            id_pipe_flush,
    output logic [XLEN-1:0] id_pipe_pc,
    output logic [XLEN-1:0] id_pipe_instruction,
    input  logic            ex_branch,
    input  logic [XLEN-1:0] ex_branch_pc,
    output logic            iram_req,
    output logic [XLEN-1:0] iram_addr,
    input  logic            iram_ready,
    input  logic            iram_rvalid,
    input  logic [XLEN-1:0] iram_rdata
);

    localparam int              OW      = $clog2(MAX_OUTSTANDING + 1);
    localparam int              CW      = $clog2(FQ_DEPTH + 1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [OW-1:0]   os_cnt_q, os_cnt_d;
    logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [XLEN-1:0] target_pc;
    logic [CW-1:0]   fq_count;
    logic            fq_full, fq_empty, fq_push, fq_pop;
    logic            os_credit, fq_credit, accept;
    fq_entry_t       push_entry, head;

    // Handshakes: a request transfers on iram_req & iram_ready; a queue entry transfers to ID on
    // id_pipe_valid & id_pipe_ready & ~id_pipe_flush; iram_rvalid is a one-cycle strobe that is
    // never back-pressured because every accepted read already owns a queue slot.
    assign os_credit = (32'(os_cnt_q) < MAX_OUTSTANDING);
    assign fq_credit = ((32'(os_cnt_q) + 32'(fq_count)) < FQ_DEPTH);
    assign iram_req  = ~rst & ~ex_branch & os_credit & fq_credit;
    assign iram_addr = fetch_pc_q;
    assign accept    = iram_req & iram_ready;
    assign target_pc = {ex_branch_pc[XLEN-1:2], 2'b00};

    assign fq_push       = iram_rvalid & ~ex_branch & (drop_cnt_q == '0);
    assign fq_pop        = id_pipe_valid & id_pipe_ready & ~id_pipe_flush & ~ex_branch;
    assign push_entry.pc    = resp_pc_q;
    assign push_entry.instr = iram_rdata;

    assign id_pipe_valid       = ~fq_empty;
    assign id_pipe_pc          = head.pc;
    assign id_pipe_instruction = head.instr;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_cnt_d = drop_cnt_q;
        os_cnt_d   = os_cnt_q + OW'(accept) - OW'(iram_rvalid);
        if (ex_branch) begin
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            // Every read still in flight after this cycle is stale, including any already
            // marked for dropping, so the drop count becomes the remaining in-flight total.
            drop_cnt_d = os_cnt_q - OW'(iram_rvalid);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (iram_rvalid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - OW'(1);
                end else begin
                    resp_pc_d = resp_pc_q + PC_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= PC_RESET_ADDR;
            resp_pc_q  <= PC_RESET_ADDR;
            os_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            os_cnt_q   <= os_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    sync_fifo #(
        .T     (fq_entry_t),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk   (clk),
        .rst   (rst),
        .clr   (ex_branch),
        .push  (fq_push),
        .wdata (push_entry),
        .pop   (fq_pop),
        .rdata (head),
        .full  (fq_full),
        .empty (fq_empty),
        .count (fq_count)
    );

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
        !(iram_rvalid && (os_cnt_q == '0)));
    a_drop_within_os: assert property (@(posedge clk) disable iff (rst)
        drop_cnt_q <= os_cnt_q);
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(fq_push && fq_full));

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Bench for if_prefetch_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_if_prefetch_buffer;

    localparam int FQ_DEPTH = 4;
    localparam int MAX_OS   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_pipe_valid, id_pipe_ready, id_pipe_flush;
    logic [31:0] id_pipe_pc, id_pipe_instruction;
    logic        ex_branch;
    logic [31:0] ex_branch_pc;
    logic        iram_req, iram_ready, iram_rvalid;
    logic [31:0] iram_addr, iram_rdata;

    always #5 clk = ~clk;

    if_prefetch_buffer #(
        .PC_RESET_ADDR   (32'h0),
        .FQ_DEPTH        (FQ_DEPTH),
        .MAX_OUTSTANDING (MAX_OS)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .id_pipe_valid       (id_pipe_valid),
        .id_pipe_ready       (id_pipe_ready),
        .id_pipe_flush       (id_pipe_flush),
        .id_pipe_pc          (id_pipe_pc),
        .id_pipe_instruction (id_pipe_instruction),
        .ex_branch           (ex_branch),
        .ex_branch_pc        (ex_branch_pc),
        .iram_req            (iram_req),
        .iram_addr           (iram_addr),
        .iram_ready          (iram_ready),
        .iram_rvalid         (iram_rvalid),
        .iram_rdata          (iram_rdata)
    );

    // Model state: reads in flight (with a stale flag) and the expected fetch queue {pc, instr}.
    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          cyc;
    } infl_t;

    infl_t       infl_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] m_fetch_pc;
    int          cyc;
    int          n_vec = 0;
    int          n_err = 0;

    logic        s_valid, s_req;
    logic [31:0] s_pc, s_instr, s_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0F0F;
    endfunction

    function automatic bit model_req();
        return !ex_branch && (infl_q.size() < MAX_OS) &&
               (infl_q.size() + exp_q.size() < FQ_DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare();
        logic [63:0] head;
        chk("id_pipe_valid", 32'(id_pipe_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            chk("id_pipe_pc", id_pipe_pc, head[63:32]);
            chk("id_pipe_instruction", id_pipe_instruction, head[31:0]);
        end
        chk("iram_req", 32'(iram_req), 32'(model_req()));
        chk("iram_addr", iram_addr, m_fetch_pc);
    endtask

    task automatic model_update();
        bit          acc, pop, do_push;
        logic [63:0] pushv;
        infl_t       e;
        acc     = model_req() && iram_ready;
        do_push = 1'b0;
        pushv   = '0;
        if (ex_branch) begin
            exp_q.delete();
            if (iram_rvalid) e = infl_q.pop_front();
            foreach (infl_q[i]) infl_q[i].stale = 1'b1;
            m_fetch_pc = {ex_branch_pc[31:2], 2'b00};
        end else begin
            if (iram_rvalid) begin
                e = infl_q.pop_front();
                if (!e.stale) begin
                    do_push = 1'b1;
                    pushv   = {e.addr, iram_rdata};
                end
            end
            pop = (exp_q.size() > 0) && id_pipe_ready && !id_pipe_flush;
            if (pop) pushv[0] = pushv[0];
            if (pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(pushv);
            if (acc) begin
                infl_q.push_back('{m_fetch_pc, 1'b0, cyc});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
    endtask

    // One clock of stimulus: drive after the edge, check at negedge, advance the model at posedge.
    task automatic step(input bit br, input logic [31:0] bpc, input bit irdy, input bit idrdy,
                        input bit want_rv);
        ex_branch     = br;
        id_pipe_flush = br;
        ex_branch_pc  = bpc;
        iram_ready    = irdy;
        id_pipe_ready = idrdy;
        if (want_rv && infl_q.size() > 0 && infl_q[0].cyc < cyc) begin
            iram_rvalid = 1'b1;
            iram_rdata  = mem_word(infl_q[0].addr);
        end else begin
            iram_rvalid = 1'b0;
            iram_rdata  = $urandom;
        end
        @(negedge clk);
        s_valid = id_pipe_valid;
        s_req   = iram_req;
        s_pc    = id_pipe_pc;
        s_instr = id_pipe_instruction;
        s_addr  = iram_addr;
        compare();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        ex_branch     = 1'b0;
        id_pipe_flush = 1'b0;
        ex_branch_pc  = '0;
        iram_ready    = 1'b1;
        id_pipe_ready = 1'b1;
        iram_rvalid   = 1'b0;
        iram_rdata    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(id_pipe_valid), 32'd0);
        chk("rst_req", 32'(iram_req), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        infl_q.delete();
        exp_q.delete();
        m_fetch_pc = 32'h0;
        cyc        = 0;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            if (s_valid) seen = 1'b1;
        end
        if (seen) begin
            chk(name, s_pc, exp_pc);
            chk({name, "_instr"}, s_instr, mem_word(exp_pc));
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no valid entry within 30 cycles, expected pc %h", name, exp_pc);
        end
    endtask

    initial begin
        int p_irdy, p_idrdy, p_rv, p_br;
        logic [31:0] bpc;

        // Streaming from reset: one pc per cycle after a two-cycle startup.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            if (k >= 2 && k < 6) chk("t1_stream_pc", s_pc, 32'(4 * (k - 2)));
        end

        // ID stalled: queue fills and requests stop, then drains in order.
        for (int k = 0; k < 10; k++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("t2_full_req", 32'(s_req), 32'd0);
        chk("t2_full_valid", 32'(s_valid), 32'd1);
        for (int k = 0; k < 10; k++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

        // Redirect with two reads outstanding.
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("t3_no_credit", 32'(iram_req), 32'd0);
        step(1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
        wait_valid("t3_first_pc", 32'h100);

        // Redirect in the same cycle as the only outstanding return.
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h100, 1'b1, 1'b1, 1'b1);
        wait_valid("t4_first_pc", 32'h100);

        // iram stall holds the address; a redirect during the stall retargets it.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            chk("t5_addr_held", s_addr, 32'h0);
        end
        step(1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("t5_addr_target", s_addr, 32'h40);

        // Unaligned target and address wrap.
        step(1'b1, 32'h203, 1'b1, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("t6_aligned", s_addr, 32'h200);
        step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("t6_wrap_hi", s_addr, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("t6_wrap_lo", s_addr, 32'h0);
        wait_valid("t6_first_pc", 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("t6_next_pc", s_pc, 32'h0);

        // Random traffic in blocks with varying pressure.
        do_reset();
        for (int blk = 0; blk < 8; blk++) begin
            p_irdy  = $urandom_range(30, 100);
            p_idrdy = $urandom_range(20, 100);
            p_rv    = $urandom_range(30, 100);
            p_br    = $urandom_range(1, 12);
            for (int k = 0; k < 500; k++) begin
                bpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                  : 32'($urandom);
                step(($urandom_range(1, 100) <= p_br) ? 1'b1 : 1'b0, bpc,
                     ($urandom_range(1, 100) <= p_irdy) ? 1'b1 : 1'b0,
                     ($urandom_range(1, 100) <= p_idrdy) ? 1'b1 : 1'b0,
                     ($urandom_range(1, 100) <= p_rv) ? 1'b1 : 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
